// File: rtl/clk_div_pkg.sv
// Shared defaults and half-period sanitising for the multi-channel clock divider.
// Latency: n/a (types/functions only). Backpressure: n/a.
// Optional phase-align port is enabled with CLKDIV_SYNC_EN.
package clk_div_pkg;

  localparam int          CNT_W_DEF        = 32;
  localparam int unsigned DEFAULT_HALF_DEF = 50_000_000;

  // A half-period of zero would never wrap; it behaves as the fastest setting instead.
  function automatic logic [63:0] sanitize_half(input logic [63:0] h);
    return (h == 64'd0) ? 64'd1 : h;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of the multi-channel divider: enables, reloads, divided clocks, ticks.
// Latency: n/a (wires only). Backpressure: none, all signals are levels or one-cycle strobes.
// sync_i exists only when CLKDIV_SYNC_EN is defined.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] half_period;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
`ifdef CLKDIV_SYNC_EN
  logic                    sync_i;

  modport master (output en, load, half_period, sync_i, input clk_out, tick);
  modport slave  (input en, load, half_period, sync_i, output clk_out, tick);
`else
  modport master (output en, load, half_period, input clk_out, tick);
  modport slave  (input en, load, half_period, output clk_out, tick);
`endif
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadow/active half-period, 50% divided clock and tick.
// Latency: outputs registered, first toggle H edges after enable. Backpressure: none.
// Phase-align input sync exists only when CLKDIV_SYNC_EN is defined.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] half_in,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(sanitize_half(64'(DEFAULT_HALF)));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             restart;

  always_comb begin
    shadow_d = load ? CNT_W'(sanitize_half(64'(half_in))) : shadow_q;
    wrap     = (cnt_q == active_q - CNT_W'(1));
`ifdef CLKDIV_SYNC_EN
    restart  = !en || sync;
`else
    restart  = !en;
`endif
    cnt_d    = cnt_q + CNT_W'(1);
    clk_d    = clk_q;
    tick_d   = 1'b0;
    active_d = active_q;
    // active only moves at cnt=0, so a shorter reload can never be overtaken by cnt.
    if (restart) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      active_d = shadow_d;
    end else if (wrap) begin
      cnt_d    = '0;
      clk_d    = ~clk_q;
      tick_d   = 1'b1;
      active_d = shadow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= RST_HALF;
      active_q <= RST_HALF;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable clock dividers / tick generators from one system clock.
// Latency: registered outputs, first toggle H edges after enable. Backpressure: none.
// Define CLKDIV_SYNC_EN to add sync_i, which phase-aligns all enabled channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  clk_div_multi_if.slave  bus
);

  logic [NUM_CH-1:0] clk_out_w;
  logic [NUM_CH-1:0] tick_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef CLKDIV_SYNC_EN
      .sync    (bus.sync_i),
`endif
      .en      (bus.en[i]),
      .load    (bus.load[i]),
      .half_in (bus.half_period[i*CNT_W +: CNT_W]),
      .clk_out (clk_out_w[i]),
      .tick    (tick_w[i])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: directed scenarios plus random enable/reload traffic
// compared against a timestamp-based reference of each channel's half-periods.
module tb_clk_div_multi;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DEF = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each channel remembers the edge index at which its current
  // half-period started; a toggle is due exactly act edges later.
  int e;
  int m_seg [NCH];
  int m_act [NCH];
  int m_sh  [NCH];
  bit m_clk [NCH];
  bit m_tick[NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_seg[c] = e; m_act[c] = DEF; m_sh[c] = DEF; m_clk[c] = 0; m_tick[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit sy;
    int h;
    e++;
    sy = 0;
`ifdef CLKDIV_SYNC_EN
    sy = bus.sync_i;
`endif
    for (int c = 0; c < NCH; c++) begin
      h = int'(bus.half_period[c*CW +: CW]);
      if (bus.load[c]) m_sh[c] = (h == 0) ? 1 : h;
      if (!bus.en[c] || sy) begin
        m_clk[c] = 0; m_tick[c] = 0; m_act[c] = m_sh[c]; m_seg[c] = e;
      end else if (e - m_seg[c] == m_act[c]) begin
        m_clk[c] = ~m_clk[c]; m_tick[c] = 1; m_act[c] = m_sh[c]; m_seg[c] = e;
      end else begin
        m_tick[c] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("clk_out[%0d]", c), 32'(bus.clk_out[c]), 32'(m_clk[c]));
      chk($sformatf("tick[%0d]", c), 32'(bus.tick[c]), 32'(m_tick[c]));
    end
    bus.load = '0;
`ifdef CLKDIV_SYNC_EN
    bus.sync_i = 1'b0;
`endif
  endtask

  task automatic set_h(input int c, input int h);
    bus.half_period[c*CW +: CW] = CW'(h);
    bus.load[c] = 1'b1;
  endtask

  initial begin
    e = 0;
    rst_n = 1'b0;
    bus.en = '0;
    bus.load = '0;
    bus.half_period = '0;
`ifdef CLKDIV_SYNC_EN
    bus.sync_i = 1'b0;
`endif
    #1;
    chk("reset_clk_out", 32'(bus.clk_out), 32'd0);
    chk("reset_tick", 32'(bus.tick), 32'd0);
    #11 rst_n = 1'b1;
    model_reset();

    // H=3 loaded while disabled: toggles on edges 3,6,9 after enable.
    set_h(0, 3);
    step();
    bus.en[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("h3_tick", 32'(bus.tick[0]), 32'((k % 3) == 0));
    end

    // H=0 behaves as H=1: tick continuously high.
    set_h(1, 0);
    step();
    bus.en[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("h0_tick", 32'(bus.tick[1]), 32'd1);
    end

    // Reload mid half-period: old half completes, then 5-cycle halves.
    set_h(2, 3);
    step();
    bus.en[2] = 1'b1;
    step();
    set_h(2, 5);
    for (int k = 2; k <= 14; k++) begin
      step();
      chk("reload_tick", 32'(bus.tick[2]), 32'(k == 3 || k == 8 || k == 13));
    end

    // Drop enable mid-period, then re-enable.
    bus.en[0] = 1'b0;
    step();
    chk("dis_clk_out", 32'(bus.clk_out[0]), 32'd0);
    bus.en[0] = 1'b1;
    for (int k = 1; k <= 7; k++) step();

    // Asynchronous reset between edges, release with all channels enabled.
    bus.en = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("arst_tick", 32'(bus.tick), 32'd0);
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("post_rst_tick", 32'(bus.tick[3]), 32'(k == DEF));
    end

`ifdef CLKDIV_SYNC_EN
    set_h(0, 2);
    set_h(1, 3);
    for (int k = 0; k < 11; k++) step();
    bus.sync_i = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("sync_tick0", 32'(bus.tick[0]), 32'(k == 2));
      chk("sync_tick1", 32'(bus.tick[1]), 32'(k == 3));
    end
`endif

    // Random enables, reloads and (when present) sync pulses.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 19) == 0) bus.en[c] = ~bus.en[c];
        if ($urandom_range(0, 9) == 0) set_h(c, int'($urandom_range(0, 6)));
      end
`ifdef CLKDIV_SYNC_EN
      if ($urandom_range(0, 49) == 0) bus.sync_i = 1'b1;
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
